// File: rtl/hash_in_streamer_pkg.sv
// hash_in_streamer_pkg: shared state encoding, word width, depth table and last-word helpers
package hash_in_streamer_pkg;

    localparam int HASH_IO_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_SQUEEZE,
        ST_DONE
    } state_t;

    // Hash-input RAM depth in words per parameter set; only L1 (680 bits) is characterised
    function automatic int ram_depth(input string parameter_set);
        return (parameter_set == "L1") ? 22 : 22;
    endfunction

    // Valid bytes in the final word for r = length % 32 (r == 0 means a full word)
    function automatic logic [2:0] tail_bytes(input logic [4:0] r);
        return (r == 5'd0) ? 3'd4 : 3'((6'(r) + 6'd7) >> 3);
    endfunction

    // Keeps the top r bits of the final word and clears everything below them
    function automatic logic [31:0] tail_mask(input logic [4:0] r);
        return (r == 5'd0) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> r);
    endfunction

endpackage

// File: rtl/hash_skid_fifo.sv
// hash_skid_fifo: 2-entry valid/ready FIFO holding RAM read data ahead of the SHAKE core
module hash_skid_fifo #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wp;
    logic         rp;
    logic         push;
    logic         pop;

    // Head of the ring drives the output; data reads as zero while empty
    always_comb begin
        in_ready  = occ != 2'd2;
        out_valid = occ != 2'd0;
        out_data  = out_valid ? mem[rp] : '0;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Two-slot ring with write/read pointers and occupancy; flush empties it in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            occ    <= 2'd0;
        end else if (flush) begin
            wp     <= 1'b0;
            rp     <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) mem[wp] <= in_data;
            wp  <= wp ^ push;
            rp  <= rp ^ pop;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/hash_in_streamer.sv
// hash_in_streamer: reads the hash-input RAM into the SHAKE core, then forwards the digest
module hash_in_streamer
    import hash_in_streamer_pkg::*;
#(
    parameter string PARAMETER_SET = "L1",
    parameter int    IO_WIDTH      = HASH_IO_WIDTH,
    parameter int    MAX_RAM_DEPTH = ram_depth(PARAMETER_SET),
    localparam int   AW            = $clog2(MAX_RAM_DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [31:0]         i_input_length,
    input  logic [31:0]         i_input_length_32,
    input  logic [31:0]         i_output_length,
    output logic [AW-1:0]       o_addr,
    output logic                o_rd_en,
    input  logic [IO_WIDTH-1:0] i_data_in,
    output logic [IO_WIDTH-1:0] o_core_din,
    output logic                o_core_din_valid,
    output logic [2:0]          o_core_din_bytes,
    output logic                o_core_din_last,
    input  logic                i_core_din_ready,
    input  logic [IO_WIDTH-1:0] i_core_dout,
    input  logic                i_core_dout_valid,
    output logic                o_core_dout_ready,
    output logic [IO_WIDTH-1:0] o_data_out,
    output logic                o_data_out_valid,
    input  logic                i_data_out_ready,
    input  logic                i_force_done,
    output logic                o_force_done_ack,
    output logic                o_busy,
    output logic                o_done
);

    localparam int CW = AW + 1;

    state_t        state;
    logic [CW-1:0] nw;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] push_cnt;
    logic [4:0]    rbits;
    logic [31:0]   out_words;
    logic [31:0]   out_cnt;
    logic          inflight;
    logic          zero_pend;
    logic [1:0]    occ;
    logic          fifo_in_ready;
    logic [35:0]   push_word;
    logic [35:0]   head;
    logic          push_valid;
    logic          rd_go;
    logic          din_xfer;
    logic          dout_active;
    logic          dout_xfer;
    logic          last_word;

    hash_skid_fifo #(.W(36)) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_force_done),
        .in_data   (push_word),
        .in_valid  (push_valid),
        .in_ready  (fifo_in_ready),
        .out_data  (head),
        .out_valid (o_core_din_valid),
        .out_ready (i_core_din_ready),
        .occ       (occ)
    );

    // Read issue (counting the word leaving this cycle), last-word shaping and digest gating
    always_comb begin
        din_xfer   = o_core_din_valid & i_core_din_ready;
        rd_go      = state == ST_ABSORB && !i_force_done && rd_cnt < nw &&
                     ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, din_xfer});
        last_word  = push_cnt + CW'(1) == nw;
        push_valid = inflight | zero_pend;
        push_word  = zero_pend ? 36'd1 :
                     {i_data_in & (last_word ? tail_mask(rbits) : 32'hFFFF_FFFF),
                      last_word ? tail_bytes(rbits) : 3'd4, last_word};
        {o_core_din, o_core_din_bytes, o_core_din_last} = head;
        o_rd_en           = rd_go;
        o_addr            = rd_go ? rd_cnt[AW-1:0] : '0;
        dout_active       = state == ST_SQUEEZE && out_cnt < out_words;
        dout_xfer         = dout_active & i_core_dout_valid & i_data_out_ready;
        o_data_out        = dout_active ? i_core_dout : '0;
        o_data_out_valid  = dout_active & i_core_dout_valid;
        o_core_dout_ready = dout_active & i_data_out_ready;
    end

    // Control FSM with its counters; abort beats every state and a start is taken only in IDLE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= ST_IDLE;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_force_done_ack <= 1'b0;
            nw               <= '0;
            rd_cnt           <= '0;
            push_cnt         <= '0;
            rbits            <= '0;
            out_words        <= '0;
            out_cnt          <= '0;
            inflight         <= 1'b0;
            zero_pend        <= 1'b0;
        end else begin
            o_force_done_ack <= i_force_done;
            o_done           <= 1'b0;
            inflight         <= rd_go;
            if (push_valid) assert (fifo_in_ready);
            if (rd_go) rd_cnt <= rd_cnt + CW'(1);
            if (push_valid) begin
                push_cnt  <= push_cnt + CW'(1);
                zero_pend <= 1'b0;
            end
            if (dout_xfer) out_cnt <= out_cnt + 32'd1;
            if (i_force_done) begin
                state     <= ST_IDLE;
                o_busy    <= 1'b0;
                inflight  <= 1'b0;
                zero_pend <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (i_start) begin
                        assert (i_input_length_32 <= 32'(32 * MAX_RAM_DEPTH) &&
                                i_input_length <= i_input_length_32);
                        nw        <= i_input_length_32[AW+5:5];
                        zero_pend <= ~|i_input_length_32[AW+5:5];
                        rbits     <= i_input_length[4:0];
                        out_words <= {5'd0, i_output_length[31:5]} + {31'd0, |i_output_length[4:0]};
                        rd_cnt    <= '0;
                        push_cnt  <= '0;
                        out_cnt   <= '0;
                        state     <= ST_ABSORB;
                        o_busy    <= 1'b1;
                    end
                    ST_ABSORB: if (din_xfer && o_core_din_last) state <= ST_SQUEEZE;
                    ST_SQUEEZE: if (out_cnt + 32'(dout_xfer) >= out_words) begin
                        state  <= ST_DONE;
                        o_done <= 1'b1;
                    end
                    ST_DONE: begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
